// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing source for the 640x480@60 Hz mode (25 MHz pixel clock).
// Produces the pixel/line counters (DrawX/DrawY), the display-active
// qualifier (blank, 1 = draw), active-low hs/vs syncs delayed by SYNC_DELAY
// cycles to line up with downstream registered RGB, line/frame boundary
// pulses and an optional completed-frame counter.
//
// Ports:
//   vga_clk      in   1   pixel clock, all logic on posedge
//   reset        in   1   synchronous, active-high
//   DrawX        out  10  horizontal counter (zero latency)
//   DrawY        out  10  vertical counter (zero latency)
//   blank        out  1   1 = visible region, aligned with DrawX/DrawY
//   hs, vs       out  1   active-low syncs, delayed by SYNC_DELAY cycles
//   sync         out  1   composite sync, constant 0
//   line_start   out  1   one-cycle pulse at hc==0 after a line wrap
//   frame_start  out  1   one-cycle pulse at (0,0) after a frame wrap
//   frame_count  out  16  completed-frame counter
//
// Optional feature macro: VGA_FRAME_COUNTER_EN
//   defined   -> frame_count is a 16-bit wrapping counter
//   undefined -> frame_count is tied to 0 (frame_start still pulses)
//
// Counters are 10 bits: H_TOTAL and V_TOTAL must not exceed 1024.
// SYNC_DELAY legal range is 0..4.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        sync,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       h_wrap, v_wrap;
    logic       hs_raw, vs_raw;

    // Next-state for the raster counters. The boundary pulses are registered
    // alongside the counters, so a pulse computed from "about to wrap" lands in
    // the same cycle the counters show 0.
    always_comb begin
        h_wrap        = (hc_q == H_LAST);
        v_wrap        = (vc_q == V_LAST);
        hc_d          = h_wrap ? 10'd0 : hc_q + 10'd1;
        vc_d          = vc_q;
        if (h_wrap) begin
            vc_d = v_wrap ? 10'd0 : vc_q + 10'd1;
        end
        line_start_d  = h_wrap;
        frame_start_d = h_wrap && v_wrap;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc_q          <= 10'd0;
            vc_q          <= 10'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign blank       = (hc_q < H_VIS) && (vc_q < V_VIS);
    assign sync        = 1'b0;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

    assign hs_raw = !((hc_q >= HS_START) && (hc_q < HS_END));
    assign vs_raw = !((vc_q >= VS_START) && (vc_q < VS_END));

    // hs/vs travel together through a SYNC_DELAY-deep shift register, bit 0 =
    // hs, bit 1 = vs. Stages reset to inactive (1) so a reset mid-sync drops
    // any pending low pulse.
    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hs = hs_raw;
            assign vs = vs_raw;
        end else begin : g_delay
            logic [1:0] sync_pipe_q [SYNC_DELAY];
            logic [1:0] sync_pipe_d [SYNC_DELAY];

            for (genvar gi = 0; gi < SYNC_DELAY; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    assign sync_pipe_d[gi] = {vs_raw, hs_raw};
                end else begin : g_tail
                    assign sync_pipe_d[gi] = sync_pipe_q[gi-1];
                end
            end

            always_ff @(posedge vga_clk) begin
                for (int i = 0; i < SYNC_DELAY; i++) begin
                    if (reset) begin
                        sync_pipe_q[i] <= 2'b11;
                    end else begin
                        sync_pipe_q[i] <= sync_pipe_d[i];
                    end
                end
            end

            assign hs = sync_pipe_q[SYNC_DELAY-1][0];
            assign vs = sync_pipe_q[SYNC_DELAY-1][1];
        end
    endgenerate

`ifdef VGA_FRAME_COUNTER_EN
    logic [15:0] frame_count_q, frame_count_d;

    // Advances on the same edge that raises frame_start; wraps naturally.
    always_comb begin
        frame_count_d = frame_start_d ? frame_count_q + 16'd1 : frame_count_q;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            frame_count_q <= 16'h0000;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`else
    assign frame_count = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench for vga_timing_gen. Three instances use the 640x480 timing
// (SYNC_DELAY 1, 0 and 4, sharing reset_d); a fourth uses a scaled-down raster
// (16 x 12, SYNC_DELAY 1, reset_s) so whole frames fit in a short run.
// Outputs are sampled on the falling clock edge; m counts rising edges since
// the relevant reset release.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

`ifdef VGA_FRAME_COUNTER_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_d = 1'b1;
    logic reset_s = 1'b1;

    logic [9:0]  dx1, dy1, dx0, dy0, dx4, dy4, dxs, dys;
    logic        bl1, hs1, vs1, sy1, ls1, fs1;
    logic        bl0, hs0, vs0, sy0, ls0, fs0;
    logic        bl4, hs4, vs4, sy4, ls4, fs4;
    logic        bls, hss, vss, sys, lss, fss;
    logic [15:0] fc1, fc0, fc4, fcs;

    int tests = 0;
    int fails = 0;

    vga_timing_gen #(.SYNC_DELAY(1)) dut (
        .vga_clk(clk), .reset(reset_d), .DrawX(dx1), .DrawY(dy1), .blank(bl1),
        .hs(hs1), .vs(vs1), .sync(sy1), .line_start(ls1), .frame_start(fs1),
        .frame_count(fc1));

    vga_timing_gen #(.SYNC_DELAY(0)) dut0 (
        .vga_clk(clk), .reset(reset_d), .DrawX(dx0), .DrawY(dy0), .blank(bl0),
        .hs(hs0), .vs(vs0), .sync(sy0), .line_start(ls0), .frame_start(fs0),
        .frame_count(fc0));

    vga_timing_gen #(.SYNC_DELAY(4)) dut4 (
        .vga_clk(clk), .reset(reset_d), .DrawX(dx4), .DrawY(dy4), .blank(bl4),
        .hs(hs4), .vs(vs4), .sync(sy4), .line_start(ls4), .frame_start(fs4),
        .frame_count(fc4));

    // Small raster: H 8+2+3+3 = 16, V 6+2+2+2 = 12, hs_raw low hc 10..12,
    // vs_raw low vc 8..9.
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_DELAY(1)
    ) dut_s (
        .vga_clk(clk), .reset(reset_s), .DrawX(dxs), .DrawY(dys), .blank(bls),
        .hs(hss), .vs(vss), .sync(sys), .line_start(lss), .frame_start(fss),
        .frame_count(fcs));

    // Expected delayed hs for the full-size raster, m edges after release.
    function automatic logic exp_hs_full(int m, int d);
        int src;
        src = m - d;
        if (src < 0) return 1'b1;
        src = src % 800;
        return !((src >= 656) && (src < 752));
    endfunction

    function automatic logic exp_vs_small(int m);
        int src;
        int vc;
        src = m - 1;
        if (src < 0) return 1'b1;
        vc = (src / 16) % 12;
        return !((vc >= 8) && (vc < 10));
    endfunction

    function automatic logic exp_hs_small(int m);
        int src;
        int hc;
        src = m - 1;
        if (src < 0) return 1'b1;
        hc = src % 16;
        return !((hc >= 10) && (hc < 13));
    endfunction

    task automatic test_reset();
        reset_d = 1'b1;
        reset_s = 1'b1;
        repeat (3) @(negedge clk);
        reset_d = 1'b0;
        #1;
        tests++; if (dx1 !== 10'd0 || dy1 !== 10'd0) begin fails++;
            $display("FAIL reset_xy got %0d,%0d want 0,0", dx1, dy1); end
        tests++; if (bl1 !== 1'b1) begin fails++;
            $display("FAIL reset_blank got %b want 1", bl1); end
        tests++; if (hs1 !== 1'b1 || vs1 !== 1'b1) begin fails++;
            $display("FAIL reset_sync got hs=%b vs=%b want 1,1", hs1, vs1); end
        tests++; if (ls1 !== 1'b0 || fs1 !== 1'b0) begin fails++;
            $display("FAIL reset_pulse got ls=%b fs=%b want 0,0", ls1, fs1); end
        tests++; if (fc1 !== 16'h0000) begin fails++;
            $display("FAIL reset_fcount got %h want 0000", fc1); end
        tests++; if (sy1 !== 1'b0) begin fails++;
            $display("FAIL reset_csync got %b want 0", sy1); end
        $display("[TB] reset: DrawX=%0d DrawY=%0d blank=%b hs=%b vs=%b", dx1, dy1, bl1, hs1, vs1);
    endtask

    task automatic test_line_timing();
        int blank_fall = -1;
        int hs_first   = -1;
        int hs_low     = 0;
        int ls_cnt     = 0;
        for (int m = 0; m <= 800; m++) begin
            if (m != 0) @(negedge clk);
            tests++; if (dx1 !== 10'(m % 800)) begin fails++;
                $display("FAIL line_drawx m=%0d got %0d want %0d", m, dx1, m % 800); end
            tests++; if (bl1 !== ((m % 800) < 640)) begin fails++;
                $display("FAIL line_blank m=%0d got %b want %b", m, bl1, (m % 800) < 640); end
            tests++; if (hs1 !== exp_hs_full(m, 1)) begin fails++;
                $display("FAIL line_hs m=%0d got %b want %b", m, hs1, exp_hs_full(m, 1)); end
            tests++; if (sy1 !== 1'b0 || vs1 !== 1'b1) begin fails++;
                $display("FAIL line_csync_vs m=%0d got sync=%b vs=%b want 0,1", m, sy1, vs1); end
            if (blank_fall < 0 && bl1 === 1'b0) blank_fall = int'(dx1);
            if (hs1 === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(dx1);
            end
            if (ls1 === 1'b1) ls_cnt++;
        end
        tests++; if (blank_fall !== 640) begin fails++;
            $display("FAIL line_blank_fall got %0d want 640", blank_fall); end
        tests++; if (hs_low !== 96 || hs_first !== 657) begin fails++;
            $display("FAIL line_hs_width got %0d from %0d want 96 from 657", hs_low, hs_first); end
        tests++; if (dx1 !== 10'd0 || dy1 !== 10'd1 || ls1 !== 1'b1 || fs1 !== 1'b0) begin fails++;
            $display("FAIL line_wrap got x=%0d y=%0d ls=%b fs=%b want 0,1,1,0", dx1, dy1, ls1, fs1); end
        tests++; if (ls_cnt !== 1) begin fails++;
            $display("FAIL line_ls_count got %0d want 1", ls_cnt); end
        $display("[TB] line: blank fall at %0d, hs low %0d cycles from %0d, wrap y=%0d", blank_fall, hs_low, hs_first, dy1);
    endtask

    task automatic test_mid_frame_reset_default();
        repeat (700) @(negedge clk);
        tests++; if (dx1 !== 10'd700 || dy1 !== 10'd1 || hs1 !== 1'b0) begin fails++;
            $display("FAIL midrst_pre got x=%0d y=%0d hs=%b want 700,1,0", dx1, dy1, hs1); end
        reset_d = 1'b1;
        @(negedge clk);
        reset_d = 1'b0;
        tests++; if (dx1 !== 10'd0 || dy1 !== 10'd0 || bl1 !== 1'b1) begin fails++;
            $display("FAIL midrst_xy got x=%0d y=%0d blank=%b want 0,0,1", dx1, dy1, bl1); end
        tests++; if (hs1 !== 1'b1 || vs1 !== 1'b1 || hs4 !== 1'b1) begin fails++;
            $display("FAIL midrst_sync got hs=%b vs=%b hs4=%b want 1,1,1", hs1, vs1, hs4); end
        tests++; if (fs1 !== 1'b0 || ls1 !== 1'b0 || fc1 !== 16'h0000) begin fails++;
            $display("FAIL midrst_pulse got fs=%b ls=%b fc=%h want 0,0,0000", fs1, ls1, fc1); end
        @(negedge clk);
        tests++; if (dx1 !== 10'd1 || hs1 !== 1'b1 || hs4 !== 1'b1 || ls1 !== 1'b0) begin fails++;
            $display("FAIL midrst_restart got x=%0d hs=%b hs4=%b ls=%b want 1,1,1,0", dx1, hs1, hs4, ls1); end
        $display("[TB] mid-line reset (700,1): restart x=%0d hs=%b", dx1, hs1);
    endtask

    task automatic test_sync_delay_sweep();
        int first0 = -1;
        int first4 = -1;
        int low0   = 0;
        int low4   = 0;
        reset_d = 1'b1;
        repeat (2) @(negedge clk);
        reset_d = 1'b0;
        for (int m = 0; m < 800; m++) begin
            if (m != 0) @(negedge clk);
            tests++; if (hs0 !== exp_hs_full(m, 0) || hs4 !== exp_hs_full(m, 4)) begin fails++;
                $display("FAIL sweep_hs m=%0d got hs0=%b hs4=%b want %b,%b", m, hs0, hs4,
                         exp_hs_full(m, 0), exp_hs_full(m, 4)); end
            tests++; if (bl0 !== (m < 640) || bl4 !== (m < 640)) begin fails++;
                $display("FAIL sweep_blank m=%0d got %b,%b want %b", m, bl0, bl4, m < 640); end
            if (hs0 === 1'b0) begin low0++; if (first0 < 0) first0 = int'(dx0); end
            if (hs4 === 1'b0) begin low4++; if (first4 < 0) first4 = int'(dx4); end
        end
        tests++; if (first0 !== 656 || low0 !== 96) begin fails++;
            $display("FAIL sweep_d0_edge got %0d (%0d low) want 656 (96)", first0, low0); end
        tests++; if (first4 !== 660 || low4 !== 96) begin fails++;
            $display("FAIL sweep_d4_edge got %0d (%0d low) want 660 (96)", first4, low4); end
        $display("[TB] sweep: hs edge d0 at %0d, d4 at %0d", first0, first4);
    endtask

    task automatic test_frame_timing();
        int vs_low   = 0;
        int vs_first = -1;
        int fs_cnt   = 0;
        int ls_cnt   = 0;
        reset_s = 1'b0;
        #1;
        tests++; if (dxs !== 10'd0 || dys !== 10'd0 || hss !== 1'b1 || vss !== 1'b1 ||
                     lss !== 1'b0 || fss !== 1'b0 || fcs !== 16'h0000) begin fails++;
            $display("FAIL frame_reset got x=%0d y=%0d hs=%b vs=%b ls=%b fs=%b fc=%h", dxs, dys, hss, vss, lss, fss, fcs); end
        for (int m = 0; m <= 192; m++) begin
            if (m != 0) @(negedge clk);
            tests++; if (dxs !== 10'(m % 16) || dys !== 10'((m / 16) % 12)) begin fails++;
                $display("FAIL frame_xy m=%0d got %0d,%0d want %0d,%0d", m, dxs, dys, m % 16, (m / 16) % 12); end
            tests++; if (vss !== exp_vs_small(m) || hss !== exp_hs_small(m)) begin fails++;
                $display("FAIL frame_sync m=%0d got hs=%b vs=%b want %b,%b", m, hss, vss, exp_hs_small(m), exp_vs_small(m)); end
            tests++; if (bls !== ((m % 16) < 8 && ((m / 16) % 12) < 6)) begin fails++;
                $display("FAIL frame_blank m=%0d got %b", m, bls); end
            tests++; if (fcs !== (FC_EN ? 16'(m / 192) : 16'h0000)) begin fails++;
                $display("FAIL frame_fcount m=%0d got %h", m, fcs); end
            if (vss === 1'b0) begin vs_low++; if (vs_first < 0) vs_first = m; end
            if (fss === 1'b1) fs_cnt++;
            if (lss === 1'b1) ls_cnt++;
        end
        tests++; if (vs_low !== 32 || vs_first !== 129) begin fails++;
            $display("FAIL frame_vs_width got %0d from m=%0d want 32 from 129", vs_low, vs_first); end
        tests++; if (fss !== 1'b1 || lss !== 1'b1 || fs_cnt !== 1 || ls_cnt !== 12) begin fails++;
            $display("FAIL frame_pulses got fs=%b ls=%b fs_cnt=%0d ls_cnt=%0d want 1,1,1,12", fss, lss, fs_cnt, ls_cnt); end
        $display("[TB] frame: vs low %0d cycles, wrap y=%0d fs=%b fc=%h", vs_low, dys, fss, fcs);
    endtask

    task automatic test_frame_count();
        for (int m = 193; m <= 384; m++) begin
            @(negedge clk);
            tests++; if (fcs !== (FC_EN ? 16'(m / 192) : 16'h0000)) begin fails++;
                $display("FAIL fcount_run m=%0d got %h", m, fcs); end
            tests++; if (fss !== (m == 384)) begin fails++;
                $display("FAIL fcount_fs m=%0d got %b want %b", m, fss, m == 384); end
        end
`ifdef VGA_FRAME_COUNTER_EN
        dut_s.frame_count_q = 16'hFFFF;
        repeat (192) @(negedge clk);
        tests++; if (fss !== 1'b1 || fcs !== 16'h0000) begin fails++;
            $display("FAIL fcount_wrap got fs=%b fc=%h want 1,0000", fss, fcs); end
`endif
        $display("[TB] frame count after second frame: %h", fcs);
    endtask

    task automatic test_mid_frame_reset_small();
        repeat (156) @(negedge clk);
        tests++; if (dxs !== 10'd12 || dys !== 10'd9 || hss !== 1'b0 || vss !== 1'b0) begin fails++;
            $display("FAIL smallrst_pre got x=%0d y=%0d hs=%b vs=%b want 12,9,0,0", dxs, dys, hss, vss); end
        reset_s = 1'b1;
        @(negedge clk);
        reset_s = 1'b0;
        tests++; if (dxs !== 10'd0 || dys !== 10'd0 || hss !== 1'b1 || vss !== 1'b1) begin fails++;
            $display("FAIL smallrst_state got x=%0d y=%0d hs=%b vs=%b want 0,0,1,1", dxs, dys, hss, vss); end
        tests++; if (fss !== 1'b0 || lss !== 1'b0 || fcs !== 16'h0000) begin fails++;
            $display("FAIL smallrst_pulse got fs=%b ls=%b fc=%h want 0,0,0000", fss, lss, fcs); end
        $display("[TB] mid-frame reset (12,9): x=%0d y=%0d fc=%h", dxs, dys, fcs);
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_mid_frame_reset_default();
        test_sync_delay_sweep();
        test_frame_timing();
        test_frame_count();
        test_mid_frame_reset_small();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
